deserializer: RTL and testbench
===============================

# deserializer

Receive-side counterpart of the Haraka-S chunk serializer. Collects a programmable number of OUTWIDTH-bit... correction: INWIDTH-bit chunks arriving on the fast bit clock `bclk` and assembles them LSB-chunk-first into one OUTWIDTH-bit word. Chunk 0 is the least-significant chunk, matching the transmit order. The assembled word is presented to the hash core through a valid/ready handshake. Sits between the byte-wide host/link interface and the 256-bit Haraka state input.

## Interface
- INWIDTH, 8, chunk width in bits.
- OUTWIDTH, 256, assembled word width; must be an integer multiple of INWIDTH.
- Derived (localparam): N = OUTWIDTH/INWIDTH; LENW = $clog2(N)+1.
- bclk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high; clock bclk.
- start  input  1  one-cycle pulse; begins a frame and latches `length`.
- length  input  LENW  number of chunks in the frame; valid range 1..N.
- in_valid  input  1  `serial_in` holds a chunk this cycle.
- serial_in  input  INWIDTH  chunk data.
- out_ready  input  1  consumer accepts `out_word`.
- out_valid  output  1  `out_word` is complete and stable.
- out_word  output  OUTWIDTH  assembled word; chunks at or above `length` are zero.
- busy  output  1  high while in COLLECT.
- overrun  output  1  sticky error flag (see Configuration).

## Operation
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - `start` with length in 1..N: clear the word and chunk counter, latch length, go to COLLECT.
  - `start` with length 0 or length > N: ignored; stay in IDLE.
- COLLECT:
  - Each cycle with `in_valid`=1 writes `serial_in` to bits [cnt*INWIDTH +: INWIDTH], then increments `cnt`.
  - When the accepted chunk is number `length` (cnt == length-1), go to HOLD.
  - `in_valid`=0 stalls; there is no timeout.
- HOLD:
  - `out_valid`=1 and `out_word` are stable.
  - `out_ready`=1 completes the transfer and returns to IDLE.
- `start` in COLLECT (valid length): abort the current frame, clear the word, restart with the new length. A chunk presented in the same cycle belongs to the new frame at index 0.
- `start` in HOLD together with `out_ready`=1: the transfer completes and the new frame begins, going directly to COLLECT. `start` in HOLD without `out_ready` is ignored.
- Unused chunk positions stay zero, because the word is cleared at frame start.
- `cnt` is LENW bits wide and never wraps, since frames end at `length` ≤ N.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_word`=0, `busy`=0, `overrun`=0, `cnt`=0.
- `start` sampled at edge k sets `busy`=1 after edge k.
- A chunk accepted at edge k is visible in `out_word` after edge k.
- Last chunk accepted at edge k sets `out_valid`=1 after edge k; `busy`=0 after the same edge.
- Minimum frame latency: `length`+1 cycles from the `start` cycle to the first `out_valid` cycle when `in_valid` is held high from the cycle after `start`.
- `out_valid` deasserts after the edge at which `out_valid` & `out_ready` are both 1.
- Reset mid-frame or mid-HOLD: immediate return to reset values; the partial word is discarded.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `DESERIALIZER_OVERRUN_EN`.
- Defined:
  - `overrun` sets when `in_valid`=1 in IDLE or HOLD and no frame start is taken that cycle, i.e. the chunk is dropped.
  - The flag is sticky and is cleared only by an accepted `start` or by reset.
  - If set and cleared in the same cycle, clear wins.
- Undefined: `overrun` is tied to 0; dropped chunks are silently ignored.

## Test plan
- Reset then start, length=4, chunks 0x11,0x22,0x33,0x44 back-to-back -> `out_valid` 5 cycles after `start`; `out_word`=0x...0044332211 with upper bits zero; `busy` low.
- Full frame: length=32, chunks 0x00..0x1F with `in_valid` toggling every cycle -> `out_word` byte i = i. `out_valid` holds while `out_ready`=0 for 10 cycles, then drops one cycle after `out_ready`=1.
- Restart: length=8, 3 chunks, then start with length=2 and chunks 0xAA,0xBB -> `out_word`=0xBBAA; no remnant of the first frame.
- Back-to-back: in HOLD, `out_ready`=1 together with start length=1 and next-cycle chunk 0x5C -> first word transferred, second word=0x5C, no idle gap.
- Boundary: start with length=0 and with length=33 -> stays IDLE, `busy`=0. Reset asserted mid-COLLECT -> all outputs 0 asynchronously.
- Overrun (macro defined): `in_valid`=1 in IDLE -> `overrun`=1 next cycle and stays set; next start -> 0. With the macro undefined, the same stimulus leaves `overrun`=0.

Source files
------------

// File: rtl/deserializer_if.sv
// Chunk-input / word-output bundle of the Haraka-S receive deserializer.
// The slave modport is the deserializer itself; the master modport is whoever drives it.
interface deserializer_if #(
    parameter int INWIDTH  = 8,
    parameter int OUTWIDTH = 256
);
    localparam int N    = OUTWIDTH / INWIDTH;
    localparam int LENW = $clog2(N) + 1;

    logic                i_start;
    logic [LENW-1:0]     i_length;
    logic                i_in_valid;
    logic [INWIDTH-1:0]  i_serial_in;
    logic                i_out_ready;
    logic                o_out_valid;
    logic [OUTWIDTH-1:0] o_out_word;
    logic                o_busy;
    logic                o_overrun;

    modport slave (
        input  i_start, i_length, i_in_valid, i_serial_in, i_out_ready,
        output o_out_valid, o_out_word, o_busy, o_overrun
    );

    modport master (
        output i_start, i_length, i_in_valid, i_serial_in, i_out_ready,
        input  o_out_valid, o_out_word, o_busy, o_overrun
    );
endinterface

// File: rtl/deserializer.sv
// Assembles 'length' INWIDTH-bit chunks, LSB chunk first, into an OUTWIDTH-bit word.
// The sticky drop flag o_overrun is built only when DESERIALIZER_OVERRUN_EN is defined.
module deserializer #(
    parameter int INWIDTH  = 8,
    parameter int OUTWIDTH = 256
) (
    input  logic           bclk,
    input  logic           reset,
    deserializer_if.slave  bus
);
    localparam int N    = OUTWIDTH / INWIDTH;
    localparam int LENW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t              r_state;
    logic [LENW-1:0]     r_cnt;
    logic [LENW-1:0]     r_len;
    logic [OUTWIDTH-1:0] r_word;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_overrun;

    logic                w_len_ok;
    logic                w_start_take;
    logic                w_run;
    logic [LENW-1:0]     w_slot;
    logic [LENW-1:0]     w_len_next;
    logic [LENW-1:0]     w_cnt_next;
    logic                w_last;
    logic                w_drop;
    logic [OUTWIDTH-1:0] w_word_next;

    // Frame-start qualification and next word/counter; a chunk arriving with start is slot 0.
    always_comb begin
        w_len_ok     = (bus.i_length != {LENW{1'b0}}) && (bus.i_length <= LENW'(N));
        w_start_take = bus.i_start && w_len_ok && ((r_state != ST_HOLD) || bus.i_out_ready);
        w_run        = w_start_take || (r_state == ST_COLLECT);
        w_slot       = w_start_take ? {LENW{1'b0}} : r_cnt;
        w_len_next   = w_start_take ? bus.i_length : r_len;
        w_last       = bus.i_in_valid && (w_slot == (w_len_next - LENW'(1)));
        w_cnt_next   = bus.i_in_valid ? (w_slot + LENW'(1)) : w_slot;
        w_drop       = bus.i_in_valid && !w_run;
        w_word_next  = w_start_take ? {OUTWIDTH{1'b0}} : r_word;
        if (bus.i_in_valid) begin
            w_word_next[int'(w_slot) * INWIDTH +: INWIDTH] = bus.i_serial_in;
        end else begin
            w_word_next = w_word_next;
        end
    end

    // Frame FSM with registered handshake outputs and overrun flag.
    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {LENW{1'b0}};
            r_len       <= {LENW{1'b0}};
            r_word      <= {OUTWIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_run) begin
                r_word <= w_word_next;
                r_cnt  <= w_cnt_next;
                r_len  <= w_len_next;
                if (w_last) begin
                    r_state     <= ST_HOLD;
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b0;
                end else begin
                    r_state     <= ST_COLLECT;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                    ST_HOLD: begin
                        if (bus.i_out_ready) begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_out_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                endcase
            end
`ifdef DESERIALIZER_OVERRUN_EN
            // An accepted start clears the flag even if a chunk is dropped that cycle.
            if (w_start_take) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
`else
            r_overrun <= 1'b0;
`endif
        end
    end

    assign bus.o_out_valid = r_out_valid;
    assign bus.o_out_word  = r_word;
    assign bus.o_busy      = r_busy;
    assign bus.o_overrun   = r_overrun;
endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: expected words are queued as frames are driven
// and compared on every out_valid/out_ready handshake.
module tb_deserializer;
    localparam int INW  = 8;
    localparam int OUTW = 256;
    localparam int LENW = $clog2(OUTW / INW) + 1;
`ifdef DESERIALIZER_OVERRUN_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    logic bclk  = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pop    = 0;
    logic [OUTW-1:0] exp_q[$];
    logic [OUTW-1:0] w;

    deserializer_if #(.INWIDTH(INW), .OUTWIDTH(OUTW)) bus ();
    deserializer #(.INWIDTH(INW), .OUTWIDTH(OUTW)) dut (.bclk(bclk), .reset(reset), .bus(bus));

    always #5 bclk = ~bclk;

    task automatic chk(input string tag, input logic [OUTW-1:0] got, input logic [OUTW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge bclk);
        #1;
    endtask

    task automatic drive_start(input int len);
        bus.i_start  = 1'b1;
        bus.i_length = LENW'(len);
        step();
        bus.i_start  = 1'b0;
    endtask

    task automatic chunk(input logic [INW-1:0] d);
        bus.i_in_valid  = 1'b1;
        bus.i_serial_in = d;
        step();
        bus.i_in_valid  = 1'b0;
    endtask

    task automatic accept();
        bus.i_out_ready = 1'b1;
        step();
        bus.i_out_ready = 1'b0;
    endtask

    // Scoreboard: a handshake is sampled mid-cycle, ahead of the edge that completes it.
    always @(negedge bclk) begin
        if (!reset && bus.o_out_valid && bus.i_out_ready) begin
            n_pop++;
            if (exp_q.size() == 0) chk("unexpected_word", bus.o_out_word, {OUTW{1'b0}});
            else                   chk("word", bus.o_out_word, exp_q.pop_front());
        end
    end

    initial begin
        bus.i_start = 1'b0; bus.i_length = '0; bus.i_in_valid = 1'b0;
        bus.i_serial_in = '0; bus.i_out_ready = 1'b0;
        #22;
        chk("rst_valid", bus.o_out_valid, 0);
        chk("rst_word", bus.o_out_word, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_overrun", bus.o_overrun, 0);
        reset = 1'b0;
        step();

        // length 4 back-to-back, latency length+1
        exp_q.push_back(256'h44332211);
        drive_start(4);
        chk("t1_busy_after_start", bus.o_busy, 1);
        chunk(8'h11);
        chk("t1_partial", bus.o_out_word, 256'h11);
        chunk(8'h22);
        chunk(8'h33);
        chk("t1_not_yet_valid", bus.o_out_valid, 0);
        chunk(8'h44);
        chk("t1_valid", bus.o_out_valid, 1);
        chk("t1_busy_low", bus.o_busy, 0);
        accept();
        chk("t1_valid_drop", bus.o_out_valid, 0);

        // full 32-chunk frame, in_valid toggling
        w = '0;
        for (int i = 0; i < 32; i++) w[i*8 +: 8] = 8'(i);
        exp_q.push_back(w);
        drive_start(32);
        for (int i = 0; i < 64; i++) begin
            bus.i_in_valid  = (i % 2 == 0);
            bus.i_serial_in = (i % 2 == 0) ? 8'(i / 2) : 8'hEE;
            step();
        end
        bus.i_in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("t2_hold_valid", bus.o_out_valid, 1);
        chk("t2_hold_word", bus.o_out_word, w);
        accept();
        chk("t2_valid_drop", bus.o_out_valid, 0);

        // restart mid-frame clears the word
        exp_q.push_back(256'hBBAA);
        drive_start(8);
        chunk(8'h01); chunk(8'h02); chunk(8'h03);
        drive_start(2);
        chk("t3_cleared", bus.o_out_word, 0);
        chk("t3_busy", bus.o_busy, 1);
        chunk(8'hAA); chunk(8'hBB);
        chk("t3_valid", bus.o_out_valid, 1);
        accept();

        // back-to-back: start with out_ready in HOLD
        exp_q.push_back(256'h77);
        exp_q.push_back(256'h5C);
        drive_start(1);
        chunk(8'h77);
        chk("t4_first_valid", bus.o_out_valid, 1);
        bus.i_out_ready = 1'b1;
        drive_start(1);
        bus.i_out_ready = 1'b0;
        chk("t4_busy_no_gap", bus.o_busy, 1);
        chk("t4_valid_low", bus.o_out_valid, 0);
        chunk(8'h5C);
        chk("t4_second_valid", bus.o_out_valid, 1);
        accept();

        // illegal lengths are ignored
        drive_start(0);
        chk("t5_len0_busy", bus.o_busy, 0);
        drive_start(33);
        chk("t5_len33_busy", bus.o_busy, 0);
        chk("t5_len33_valid", bus.o_out_valid, 0);
        chk("t5_no_overrun", bus.o_overrun, 0);

        // dropped chunk in IDLE
        chunk(8'h66);
        chk("t6_overrun_set", bus.o_overrun, OVR_EN);
        step(); step();
        chk("t6_overrun_sticky", bus.o_overrun, OVR_EN);
        exp_q.push_back(256'h99);
        drive_start(1);
        chk("t6_overrun_clear", bus.o_overrun, 0);
        chunk(8'h99);
        accept();

        // asynchronous reset mid-COLLECT
        drive_start(4);
        chunk(8'h12); chunk(8'h34);
        chk("t7_partial", bus.o_out_word, 256'h3412);
        reset = 1'b1;
        #1;
        chk("t7_rst_word", bus.o_out_word, 0);
        chk("t7_rst_busy", bus.o_busy, 0);
        chk("t7_rst_valid", bus.o_out_valid, 0);
        step();
        reset = 1'b0;
        step();
        chk("t7_idle_after", bus.o_busy, 0);

        chk("queue_empty", exp_q.size(), 0);
        chk("handshakes", n_pop, 6);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
